// File: rtl/actuator_interlock.sv
// actuator_interlock
//   Safety interlock between the washer processor's fill/release/forward/
//   reverse strobes and the physical valves and drum motor. Opposing
//   actuators are mutually exclusive, motor direction changes pass through a
//   dead-time brake, everything is gated on door and water level, and a fill
//   valve held open too long latches a fault.
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   synchronous reset, active-high
//     req_fill     in   fill request
//     req_release  in   drain request
//     req_forward  in   drum forward request
//     req_reverse  in   drum reverse request
//     door_closed  in   1 = door closed and locked
//     level_full   in   1 = drum full
//     fault_clr    in   clears a latched fill-timeout fault
//     valve_fill   out  fill valve drive
//     valve_drain  out  drain valve drive
//     motor_fwd    out  motor forward drive
//     motor_rev    out  motor reverse drive
//     conflict     out  opposing requests seen in the same cycle
//     fault        out  latched fill-timeout fault
//
//   Motor FSM
//     state     | meaning
//     ST_IDLE   | motor off, waiting for a single-direction request
//     ST_FWD    | driving forward
//     ST_REV    | driving reverse
//     ST_BRAKE  | motor off for DEAD_TIME cycles, requests ignored
module actuator_interlock #(
   parameter int unsigned DEAD_TIME    = 8,
   parameter int unsigned FILL_TIMEOUT = 1000,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic req_fill,
   input  logic req_release,
   input  logic req_forward,
   input  logic req_reverse,
   input  logic door_closed,
   input  logic level_full,
   input  logic fault_clr,
   output logic valve_fill,
   output logic valve_drain,
   output logic motor_fwd,
   output logic motor_rev,
   output logic conflict,
   output logic fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FWD   = 2'd1,
      ST_REV   = 2'd2,
      ST_BRAKE = 2'd3
   } motor_state_t;

   localparam logic [CNT_WIDTH-1:0] DEAD_LOAD = CNT_WIDTH'(DEAD_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] FILL_LOAD = CNT_WIDTH'(FILL_TIMEOUT - 1);

   motor_state_t         state_q;
   motor_state_t         state_d;
   logic [CNT_WIDTH-1:0] dead_cnt_q;
   logic [CNT_WIDTH-1:0] dead_cnt_d;
   logic [CNT_WIDTH-1:0] fill_left_q;
   logic                 ok;
   logic                 fill_tc;

   assign ok = door_closed & ~fault;

   // Fill watchdog runs as a down-counter: it is reloaded every cycle the
   // valve is shut, so the terminal count is hit on the FILL_TIMEOUT-th
   // consecutive open cycle.
   assign fill_tc = valve_fill & (fill_left_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dead_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_forward & ~req_reverse & ok) begin
               state_d = ST_FWD;
            end else if (req_reverse & ~req_forward & ok) begin
               state_d = ST_REV;
            end
         end
         ST_FWD: begin
            if (~req_forward | req_reverse | ~ok) begin
               state_d    = ST_BRAKE;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         ST_REV: begin
            if (~req_reverse | req_forward | ~ok) begin
               state_d    = ST_BRAKE;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         ST_BRAKE: begin
            if (dead_cnt_q != '0) begin
               dead_cnt_d = dead_cnt_q - 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Decoded straight from the state register, so the two drives can never
   // be high together.
   assign motor_fwd = (state_q == ST_FWD);
   assign motor_rev = (state_q == ST_REV);

   always_ff @(posedge clk) begin
      if (rst) begin
         valve_fill  <= 1'b0;
         valve_drain <= 1'b0;
         conflict    <= 1'b0;
      end else begin
         valve_fill  <= req_fill & ~req_release & door_closed & ~level_full & ~fault;
         valve_drain <= req_release & ~req_fill & ~fault;
         conflict    <= (req_fill & req_release) | (req_forward & req_reverse);
      end
   end

   // Counter is frozen while the fault is latched so it stays at terminal
   // count; it reloads once the fault is cleared and the valve has closed.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_left_q <= '0;
      end else if (!fault) begin
         if (!valve_fill) begin
            fill_left_q <= FILL_LOAD;
         end else if (fill_left_q != '0) begin
            fill_left_q <= fill_left_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fault <= 1'b0;
      end else if (fault_clr) begin
         fault <= 1'b0;
      end else if (fill_tc) begin
         fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_actuator_interlock.sv
// tb_actuator_interlock
//   Directed self-checking bench for actuator_interlock with the default
//   parameters (DEAD_TIME=8, FILL_TIMEOUT=1000). Inputs change 1 ns after a
//   rising edge and outputs are sampled at the same point.
module tb_actuator_interlock;

   logic clk = 1'b0;
   logic rst;
   logic req_fill;
   logic req_release;
   logic req_forward;
   logic req_reverse;
   logic door_closed;
   logic level_full;
   logic fault_clr;
   logic valve_fill;
   logic valve_drain;
   logic motor_fwd;
   logic motor_rev;
   logic conflict;
   logic fault;

   int n_assert = 0;
   int n_fail   = 0;

   actuator_interlock #(
      .DEAD_TIME   (8),
      .FILL_TIMEOUT(1000),
      .CNT_WIDTH   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_fill   (req_fill),
      .req_release(req_release),
      .req_forward(req_forward),
      .req_reverse(req_reverse),
      .door_closed(door_closed),
      .level_full (level_full),
      .fault_clr  (fault_clr),
      .valve_fill (valve_fill),
      .valve_drain(valve_drain),
      .motor_fwd  (motor_fwd),
      .motor_rev  (motor_rev),
      .conflict   (conflict),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst         = 1'b1;
      req_fill    = 1'b0;
      req_release = 1'b0;
      req_forward = 1'b1;
      req_reverse = 1'b0;
      door_closed = 1'b1;
      level_full  = 1'b0;
      fault_clr   = 1'b0;

      // reset holds everything low even with a forward request present
      tick();
      tick();
      chk("rst_motor_fwd", motor_fwd, 1'b0);
      chk("rst_motor_rev", motor_rev, 1'b0);
      chk("rst_valve_fill", valve_fill, 1'b0);
      chk("rst_valve_drain", valve_drain, 1'b0);
      chk("rst_conflict", conflict, 1'b0);
      chk("rst_fault", fault, 1'b0);

      // 1. forward run, then drop: 8 BRAKE + 1 IDLE before a held request restarts
      rst = 1'b0;
      tick();
      chk("fwd_start", motor_fwd, 1'b1);
      chk("fwd_start_rev", motor_rev, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      chk("fwd_hold", motor_fwd, 1'b1);
      req_forward = 1'b0;
      tick();
      chk("fwd_drop", motor_fwd, 1'b0);
      req_forward = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("brake_ignore_%0d", i), motor_fwd, 1'b0);
      end
      tick();
      chk("fwd_restart", motor_fwd, 1'b1);

      // 2. direct FWD -> REV change: 9 cycles with both drives low
      req_forward = 1'b0;
      req_reverse = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("rev_gap_fwd_%0d", i), motor_fwd, 1'b0);
         chk($sformatf("rev_gap_rev_%0d", i), motor_rev, 1'b0);
      end
      tick();
      chk("rev_start", motor_rev, 1'b1);
      chk("rev_start_fwd", motor_fwd, 1'b0);
      chk("rev_no_conflict", conflict, 1'b0);

      // 3. opposing requests
      req_forward = 1'b1;
      tick();
      chk("both_dir_conflict", conflict, 1'b1);
      chk("both_dir_rev_off", motor_rev, 1'b0);
      for (int i = 0; i < 12; i++) tick();
      chk("both_dir_fwd_idle", motor_fwd, 1'b0);
      chk("both_dir_rev_idle", motor_rev, 1'b0);
      chk("both_dir_conflict_held", conflict, 1'b1);
      req_forward = 1'b0;
      req_reverse = 1'b0;
      req_fill    = 1'b1;
      req_release = 1'b1;
      tick();
      chk("both_valve_fill", valve_fill, 1'b0);
      chk("both_valve_drain", valve_drain, 1'b0);
      chk("both_valve_conflict", conflict, 1'b1);
      req_fill = 1'b0;
      tick();
      chk("drain_only", valve_drain, 1'b1);
      chk("drain_only_conflict", conflict, 1'b0);
      door_closed = 1'b0;
      tick();
      chk("drain_door_open", valve_drain, 1'b1);
      req_forward = 1'b1;
      req_release = 1'b0;
      tick();
      chk("door_open_no_start", motor_fwd, 1'b0);
      door_closed = 1'b1;
      req_forward = 1'b0;
      tick();

      // 5. door opens while running forward and filling
      req_forward = 1'b1;
      req_fill    = 1'b1;
      tick();
      chk("run_fill_motor", motor_fwd, 1'b1);
      chk("run_fill_valve", valve_fill, 1'b1);
      tick();
      door_closed = 1'b0;
      tick();
      chk("door_open_motor", motor_fwd, 1'b0);
      chk("door_open_fill", valve_fill, 1'b0);
      chk("door_open_drain", valve_drain, 1'b0);
      chk("door_open_fault", fault, 1'b0);
      door_closed = 1'b1;
      req_forward = 1'b0;
      req_fill    = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      // 6. level_full interrupts a fill and restarts the watchdog
      req_forward = 1'b1;
      req_fill    = 1'b1;
      tick();
      chk("fill_a_valve", valve_fill, 1'b1);
      chk("fill_a_motor", motor_fwd, 1'b1);
      for (int i = 0; i < 599; i++) tick();
      chk("fill_a_600_nofault", fault, 1'b0);
      level_full = 1'b1;
      tick();
      chk("level_full_fill", valve_fill, 1'b0);
      chk("level_full_fault", fault, 1'b0);
      level_full = 1'b0;
      tick();
      chk("fill_b_valve", valve_fill, 1'b1);

      // 4. uninterrupted fill times out after 1000 open cycles
      for (int i = 0; i < 999; i++) tick();
      chk("fill_b_999_fault", fault, 1'b0);
      chk("fill_b_999_valve", valve_fill, 1'b1);
      chk("fill_b_999_motor", motor_fwd, 1'b1);
      tick();
      chk("timeout_fault", fault, 1'b1);
      chk("timeout_valve_still", valve_fill, 1'b1);
      tick();
      chk("fault_valve_off", valve_fill, 1'b0);
      chk("fault_motor_brake", motor_fwd, 1'b0);
      req_fill    = 1'b0;
      req_release = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("fault_latched", fault, 1'b1);
      chk("fault_blocks_drain", valve_drain, 1'b0);
      chk("fault_blocks_motor", motor_fwd, 1'b0);
      fault_clr = 1'b1;
      tick();
      chk("fault_cleared", fault, 1'b0);
      fault_clr = 1'b0;
      tick();
      chk("drain_after_clr", valve_drain, 1'b1);

      // reset mid-operation
      rst = 1'b1;
      tick();
      chk("mid_rst_drain", valve_drain, 1'b0);
      chk("mid_rst_motor", motor_fwd, 1'b0);
      chk("mid_rst_fault", fault, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
